// File: rtl/midi_stream_parser.sv
// midi_stream_parser
//   Converts a raw received MIDI byte stream into the parsed byte interface
//   used by the synth controller input mux. It tracks running status, the
//   expected message length for each status type, and SysEx framing. Realtime
//   bytes (F8-FF) go out on a separate strobe and leave the parse state alone.
//
// Ports
//   reg_clk      : system register clock
//   reset_reg    : synchronous active-high reset
//   rx_valid     : one-cycle strobe, rx_byte is valid
//   rx_byte      : received MIDI byte
//   byteready    : one-cycle strobe, parsed byte is valid
//   cur_status   : status in force for the presented byte (00 = none)
//   midibyte_nr  : 0 = status byte, 1..N = data byte index
//   midi_in_data : byte being presented
//   msg_done     : one-cycle strobe, message or SysEx frame complete
//   rt_valid     : one-cycle strobe, realtime byte received
//   rt_byte      : realtime byte value
//   drop_cnt     : orphan data bytes discarded (saturating)
//   All outputs are registered one cycle after rx_valid.
module midi_stream_parser #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic              reg_clk,
  input  logic              reset_reg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              byteready,
  output logic [7:0]        cur_status,
  output logic [CNT_W-1:0]  midibyte_nr,
  output logic [7:0]        midi_in_data,
  output logic              msg_done,
  output logic              rt_valid,
  output logic [7:0]        rt_byte,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StChan  = 2'd1;
  localparam logic [1:0] StSysex = 2'd2;

  // Number of data bytes that follow a status byte. F4/F5 are undefined and
  // treated as having no data.
  function automatic logic [1:0] msg_len(input logic [7:0] st);
    logic [1:0] len;
    len = 2'd0;
    unique case (st[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        if (st == 8'hF2) begin
          len = 2'd2;
        end else if (st == 8'hF1 || st == 8'hF3) begin
          len = 2'd1;
        end
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  nr_q, nr_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        data_q, data_d;
  logic              br_q, br_d;
  logic              done_q, done_d;
  logic              rt_q, rt_d;
  logic [7:0]        rt_byte_q, rt_byte_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0]  idx_inc;
  logic [1:0]        rx_len;

  assign idx_inc = idx_q + 1'b1;
  assign rx_len  = msg_len(rx_byte);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nr_d      = nr_q;
    // Once the parser has fallen back to idle, the presented status clears on
    // the following cycle so the last byte of a message still shows its status.
    status_d  = (state_q == StIdle) ? 8'h00 : status_q;
    data_d    = data_q;
    br_d      = 1'b0;
    done_d    = 1'b0;
    rt_d      = 1'b0;
    rt_byte_d = rt_byte_q;
    drop_d    = drop_q;

    if (rx_valid) begin
      if (rx_byte >= 8'hF8) begin
        rt_d      = 1'b1;
        rt_byte_d = rx_byte;
      end else if (rx_byte[7]) begin
        if (rx_byte == 8'hF7) begin
          if (state_q == StSysex) begin
            br_d     = 1'b1;
            data_d   = rx_byte;
            nr_d     = idx_q;
            done_d   = 1'b1;
            status_d = status_q;
          end else begin
            status_d = 8'h00;
          end
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          br_d     = 1'b1;
          data_d   = rx_byte;
          nr_d     = '0;
          idx_d    = '0;
          status_d = rx_byte;
          // A new status inside SysEx implicitly terminates the frame.
          done_d   = (state_q == StSysex);
          if (rx_byte == 8'hF0) begin
            state_d = StSysex;
          end else if (rx_len == 2'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StChan;
          end
        end
      end else begin
        unique case (state_q)
          StChan: begin
            br_d     = 1'b1;
            data_d   = rx_byte;
            nr_d     = idx_inc;
            status_d = status_q;
            if (idx_inc == CNT_W'(msg_len(status_q))) begin
              done_d = 1'b1;
              idx_d  = '0;
              // System common messages do not establish running status.
              if (status_q[7:4] == 4'hF) begin
                state_d = StIdle;
              end
            end else begin
              idx_d = idx_inc;
            end
          end
          StSysex: begin
            br_d     = 1'b1;
            data_d   = rx_byte;
            status_d = status_q;
            if (idx_q != '1) begin
              idx_d = idx_inc;
              nr_d  = idx_inc;
            end else begin
              nr_d = idx_q;
            end
          end
          default: begin
            if (drop_q != '1) begin
              drop_d = drop_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      nr_q      <= '0;
      status_q  <= 8'h00;
      data_q    <= 8'h00;
      br_q      <= 1'b0;
      done_q    <= 1'b0;
      rt_q      <= 1'b0;
      rt_byte_q <= 8'h00;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      nr_q      <= nr_d;
      status_q  <= status_d;
      data_q    <= data_d;
      br_q      <= br_d;
      done_q    <= done_d;
      rt_q      <= rt_d;
      rt_byte_q <= rt_byte_d;
      drop_q    <= drop_d;
    end
  end

  assign byteready    = br_q;
  assign cur_status   = status_q;
  assign midibyte_nr  = nr_q;
  assign midi_in_data = data_q;
  assign msg_done     = done_q;
  assign rt_valid     = rt_q;
  assign rt_byte      = rt_byte_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_midi_stream_parser.sv
// tb_midi_stream_parser
//   Directed, table-driven bench for midi_stream_parser. Each table row is one
//   clock of stimulus and the registered outputs expected after that edge.
module tb_midi_stream_parser;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       byteready;
  logic [7:0] cur_status;
  logic [7:0] midibyte_nr;
  logic [7:0] midi_in_data;
  logic       msg_done;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  midi_stream_parser #(
    .CNT_W (8),
    .DROP_W(8)
  ) dut (
    .reg_clk     (clk),
    .reset_reg   (rst),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .byteready   (byteready),
    .cur_status  (cur_status),
    .midibyte_nr (midibyte_nr),
    .midi_in_data(midi_in_data),
    .msg_done    (msg_done),
    .rt_valid    (rt_valid),
    .rt_byte     (rt_byte),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] rx;
    logic       br;
    logic [7:0] st;
    logic [7:0] nr;
    logic [7:0] dat;
    logic       done;
    logic       rt;
    logic [7:0] rtb;
    logic [7:0] drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic [7:0] rx, input logic br,
                              input logic [7:0] st, input logic [7:0] nr,
                              input logic [7:0] dat, input logic done, input logic rt,
                              input logic [7:0] rtb, input logic [7:0] drop);
    vec_t v;
    v.vld = vld; v.rx = rx; v.br = br; v.st = st; v.nr = nr;
    v.dat = dat; v.done = done; v.rt = rt; v.rtb = rtb; v.drop = drop;
    return v;
  endfunction

  // Present one byte (or an idle cycle) and sample 1 ns after the edge.
  task automatic step(input logic vld, input logic [7:0] b);
    @(negedge clk);
    rx_valid = vld;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_ctrl(input string name, input vec_t v);
    chk(name, {8'h0, byteready, msg_done, rt_valid, 5'h0, cur_status, drop_cnt},
        {8'h0, v.br, v.done, v.rt, 5'h0, v.st, v.drop});
    chk({name, "_rtb"}, {24'h0, rt_byte}, {24'h0, v.rtb});
    if (v.br) begin
      chk({name, "_nrdat"}, {16'h0, midibyte_nr, midi_in_data}, {16'h0, v.nr, v.dat});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;

    //            vld rx     br st     nr     dat    dn rt rtb    drop
    vecs.push_back(mk(1, 8'h90, 1, 8'h90, 8'd0, 8'h90, 0, 0, 8'h00, 8'd0));
    vecs.push_back(mk(1, 8'h3C, 1, 8'h90, 8'd1, 8'h3C, 0, 0, 8'h00, 8'd0));
    vecs.push_back(mk(1, 8'h64, 1, 8'h90, 8'd2, 8'h64, 1, 0, 8'h00, 8'd0));
    vecs.push_back(mk(1, 8'h40, 1, 8'h90, 8'd1, 8'h40, 0, 0, 8'h00, 8'd0));
    vecs.push_back(mk(1, 8'h00, 1, 8'h90, 8'd2, 8'h00, 1, 0, 8'h00, 8'd0));
    vecs.push_back(mk(1, 8'h3C, 1, 8'h90, 8'd1, 8'h3C, 0, 0, 8'h00, 8'd0));
    vecs.push_back(mk(1, 8'hF8, 0, 8'h90, 8'd0, 8'h00, 0, 1, 8'hF8, 8'd0));
    vecs.push_back(mk(1, 8'h64, 1, 8'h90, 8'd2, 8'h64, 1, 0, 8'hF8, 8'd0));
    // SysEx frame
    vecs.push_back(mk(1, 8'hF0, 1, 8'hF0, 8'd0, 8'hF0, 0, 0, 8'hF8, 8'd0));
    vecs.push_back(mk(1, 8'h7D, 1, 8'hF0, 8'd1, 8'h7D, 0, 0, 8'hF8, 8'd0));
    vecs.push_back(mk(1, 8'h01, 1, 8'hF0, 8'd2, 8'h01, 0, 0, 8'hF8, 8'd0));
    vecs.push_back(mk(1, 8'h02, 1, 8'hF0, 8'd3, 8'h02, 0, 0, 8'hF8, 8'd0));
    vecs.push_back(mk(1, 8'hF7, 1, 8'hF0, 8'd3, 8'hF7, 1, 0, 8'hF8, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'hF8, 8'd0));
    // Orphan data bytes
    vecs.push_back(mk(1, 8'h3C, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'hF8, 8'd1));
    vecs.push_back(mk(1, 8'h64, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'hF8, 8'd2));
    // One-data-byte messages with running status
    vecs.push_back(mk(1, 8'hC5, 1, 8'hC5, 8'd0, 8'hC5, 0, 0, 8'hF8, 8'd2));
    vecs.push_back(mk(1, 8'h07, 1, 8'hC5, 8'd1, 8'h07, 1, 0, 8'hF8, 8'd2));
    vecs.push_back(mk(1, 8'h08, 1, 8'hC5, 8'd1, 8'h08, 1, 0, 8'hF8, 8'd2));
    // SysEx ended implicitly by a channel status
    vecs.push_back(mk(1, 8'hF0, 1, 8'hF0, 8'd0, 8'hF0, 0, 0, 8'hF8, 8'd2));
    vecs.push_back(mk(1, 8'h01, 1, 8'hF0, 8'd1, 8'h01, 0, 0, 8'hF8, 8'd2));
    vecs.push_back(mk(1, 8'hC2, 1, 8'hC2, 8'd0, 8'hC2, 1, 0, 8'hF8, 8'd2));
    vecs.push_back(mk(1, 8'h05, 1, 8'hC2, 8'd1, 8'h05, 1, 0, 8'hF8, 8'd2));
    // Stray F7 cancels running status
    vecs.push_back(mk(1, 8'hF7, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'hF8, 8'd2));
    vecs.push_back(mk(1, 8'h05, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'hF8, 8'd3));
    // System common: no running status afterwards
    vecs.push_back(mk(1, 8'hF1, 1, 8'hF1, 8'd0, 8'hF1, 0, 0, 8'hF8, 8'd3));
    vecs.push_back(mk(1, 8'h05, 1, 8'hF1, 8'd1, 8'h05, 1, 0, 8'hF8, 8'd3));
    vecs.push_back(mk(1, 8'h06, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'hF8, 8'd4));
    vecs.push_back(mk(1, 8'hF6, 1, 8'hF6, 8'd0, 8'hF6, 1, 0, 8'hF8, 8'd4));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'hF8, 8'd4));
    vecs.push_back(mk(1, 8'hFE, 0, 8'h00, 8'd0, 8'h00, 0, 1, 8'hFE, 8'd4));

    do_reset();
    chk_ctrl("reset", mk(0, 8'h00, 0, 8'h00, 8'd0, 8'h00, 0, 0, 8'h00, 8'd0));
    chk("reset_nrdat", {16'h0, midibyte_nr, midi_in_data}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vld, vecs[i].rx);
      chk_ctrl($sformatf("vec%0d", i), vecs[i]);
    end

    // Drop counter saturates
    for (int i = 0; i < 300; i++) step(1'b1, 8'h11);
    chk("drop_sat", {24'h0, drop_cnt}, 32'hFF);
    chk("drop_sat_nobr", {31'h0, byteready}, 32'h0);

    // SysEx byte index saturates at all-ones, F7 keeps the last count
    step(1'b1, 8'hF0);
    for (int i = 0; i < 300; i++) step(1'b1, 8'h22);
    chk("sx_sat_nr", {24'h0, midibyte_nr}, 32'hFF);
    chk("sx_sat_br", {24'h0, cur_status}, 32'hF0);
    step(1'b1, 8'hF7);
    chk("sx_sat_f7", {15'h0, byteready, msg_done, 7'h0, midibyte_nr},
        {15'h0, 1'b1, 1'b1, 7'h0, 8'hFF});

    // Reset mid-message discards the partial message
    step(1'b1, 8'h90);
    step(1'b1, 8'h3C);
    do_reset();
    chk("mid_reset", {16'h0, cur_status, drop_cnt}, 32'h0);
    step(1'b1, 8'h64);
    chk("mid_reset_drop", {23'h0, byteready, drop_cnt}, {23'h0, 1'b0, 8'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
